// File: rtl/center_reporter.sv
// center_reporter: waits for a READY-qualified center (Xc/Yc) to hold steady for
// STABLE_CYCLES samples, then queues a report {x, y, delta} in a small FIFO drained
// through a valid/ack handshake. Reports lost to a full FIFO are counted in DROP_CNT.
// Optional feature macro: CENTER_REPORTER_DELTA_EN (when defined, store |dX|+|dY| per
// entry; when undefined, OUT_DELTA is tied to 0 and entries hold only x and y).
module center_reporter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Xc,
  input  logic [7:0] Yc,
  input  logic       READY,
  input  logic       OUT_ACK,
  output logic       OUT_VALID,
  output logic [7:0] OUT_X,
  output logic [7:0] OUT_Y,
  output logic [8:0] OUT_DELTA,
  output logic [7:0] DROP_CNT
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef CENTER_REPORTER_DELTA_EN
  localparam int unsigned EntryW = 25;
`else
  localparam int unsigned EntryW = 16;
`endif
  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
  localparam logic [3:0] TrigCnt   = 4'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [7:0]        prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        last_x_q, last_y_q;
  logic              rep_vld_q;
  logic [7:0]        drop_cnt_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];

  logic              same, is_last, trigger, full, out_valid, pop, push, drop;
  logic [EntryW-1:0] entry, head;

  assign same      = (Xc == prev_x_q) && (Yc == prev_y_q);
  // A stable center equal to the last accepted report is not reported again.
  assign is_last   = rep_vld_q && (Xc == last_x_q) && (Yc == last_y_q);
  // cnt saturates at STABLE_CYCLES, so this matches only once per stable run.
  assign trigger   = READY && same && (cnt_q == TrigCnt) && !is_last;
  assign full      = (count_q == FullCnt);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && OUT_ACK;
  assign push      = trigger && (!full || pop);
  assign drop      = trigger && full && !pop;

  // Build the report entry from the current sample and the last accepted report.
`ifdef CENTER_REPORTER_DELTA_EN
  logic [7:0] dx, dy;
  logic [8:0] delta;
  always_comb begin
    dx    = (Xc >= last_x_q) ? (Xc - last_x_q) : (last_x_q - Xc);
    dy    = (Yc >= last_y_q) ? (Yc - last_y_q) : (last_y_q - Yc);
    delta = rep_vld_q ? ({1'b0, dx} + {1'b0, dy}) : 9'd0;
    entry = {Xc, Yc, delta};
  end
`else
  always_comb begin
    entry = {Xc, Yc};
  end
`endif

  // Stability tracker next state: restart on READY low or a new value.
  always_comb begin
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    cnt_d    = cnt_q;
    if (!READY) begin
      cnt_d = 4'd0;
    end else if ((cnt_q == 4'd0) || !same) begin
      prev_x_d = Xc;
      prev_y_d = Yc;
      cnt_d    = 4'd1;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Tracker state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prev_x_q <= 8'd0;
      prev_y_q <= 8'd0;
      cnt_q    <= 4'd0;
    end else begin
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      cnt_q    <= cnt_d;
    end
  end

  // Last-reported memory and drop counter; only an accepted push moves "last".
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_x_q   <= 8'd0;
      last_y_q   <= 8'd0;
      rep_vld_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        last_x_q  <= Xc;
        last_y_q  <= Yc;
        rep_vld_q <= 1'b1;
      end
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Report FIFO: pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Outputs come straight from registered head storage.
  assign head      = mem_q[rd_ptr_q];
  assign OUT_VALID = out_valid;
  assign OUT_X     = head[EntryW-1 -: 8];
  assign OUT_Y     = head[EntryW-9 -: 8];
`ifdef CENTER_REPORTER_DELTA_EN
  assign OUT_DELTA = head[8:0];
`else
  assign OUT_DELTA = 9'd0;
`endif
  assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_center_reporter.sv
// Directed bench for center_reporter (STABLE_CYCLES=4, FIFO_DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_center_reporter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] Xc, Yc;
  logic       READY, OUT_ACK;
  logic       OUT_VALID;
  logic [7:0] OUT_X, OUT_Y, DROP_CNT;
  logic [8:0] OUT_DELTA;

  int checks = 0;
  int errors = 0;

  // Bench copy of the last accepted report, used for expected deltas.
  logic [7:0] lx, ly;
  logic       lv;

  center_reporter #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .Xc(Xc), .Yc(Yc), .READY(READY), .OUT_ACK(OUT_ACK),
    .OUT_VALID(OUT_VALID), .OUT_X(OUT_X), .OUT_Y(OUT_Y), .OUT_DELTA(OUT_DELTA),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [7:0] x, input logic [7:0] y, input int n);
    READY = 1'b1;
    Xc    = x;
    Yc    = y;
    repeat (n) step();
  endtask

  function automatic logic [8:0] exp_delta(input logic [7:0] x, input logic [7:0] y);
`ifdef CENTER_REPORTER_DELTA_EN
    logic [8:0] ax, ay;
    ax = (x >= lx) ? {1'b0, x - lx} : {1'b0, lx - x};
    ay = (y >= ly) ? {1'b0, y - ly} : {1'b0, ly - y};
    return lv ? (ax + ay) : 9'd0;
`else
    return 9'd0;
`endif
  endfunction

  task automatic do_reset();
    RESET = 1'b0; READY = 1'b0; OUT_ACK = 1'b0; Xc = 8'd0; Yc = 8'd0;
    lx = 8'd0; ly = 8'd0; lv = 1'b0;
    repeat (3) step();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", OUT_VALID);
    end
    checks++;
    if (OUT_X !== 8'd0 || OUT_Y !== 8'd0) begin
      errors++; $display("FAIL reset_xy: got %h,%h want 00,00", OUT_X, OUT_Y);
    end
    checks++;
    if (OUT_DELTA !== 9'd0) begin
      errors++; $display("FAIL reset_delta: got %0d want 0", OUT_DELTA);
    end
    checks++;
    if (DROP_CNT !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got %0d want 0", DROP_CNT);
    end
  endtask

  task automatic test_first_report();
    hold(8'h40, 8'h20, 3);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL first_early: valid %b at cycle 3 want 0", OUT_VALID);
    end
    step();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_X !== 8'h40 || OUT_Y !== 8'h20 || OUT_DELTA !== 9'd0) begin
      errors++;
      $display("FAIL first_entry: got v%b %h,%h,%0d want v1 40,20,0",
               OUT_VALID, OUT_X, OUT_Y, OUT_DELTA);
    end
    step();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_X !== 8'h40 || OUT_Y !== 8'h20) begin
      errors++;
      $display("FAIL first_hold: got v%b %h,%h want v1 40,20", OUT_VALID, OUT_X, OUT_Y);
    end
    OUT_ACK = 1'b1;
    step();
    OUT_ACK = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL first_single: valid %b after one pop want 0", OUT_VALID);
    end
    lx = 8'h40; ly = 8'h20; lv = 1'b1;
  endtask

  task automatic test_delta_suppression();
    logic [8:0] want;
`ifdef CENTER_REPORTER_DELTA_EN
    want = 9'd13;
`else
    want = 9'd0;
`endif
    hold(8'h40, 8'h20, 20);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL suppress: valid %b want 0", OUT_VALID);
    end
    hold(8'h45, 8'h18, 4);
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_X !== 8'h45 || OUT_Y !== 8'h18 || OUT_DELTA !== want) begin
      errors++;
      $display("FAIL delta_entry: got v%b %h,%h,%0d want v1 45,18,%0d",
               OUT_VALID, OUT_X, OUT_Y, OUT_DELTA, want);
    end
    OUT_ACK = 1'b1;
    step();
    OUT_ACK = 1'b0;
    lx = 8'h45; ly = 8'h18; lv = 1'b1;
  endtask

  task automatic test_interrupted();
    hold(8'h10, 8'h10, 3);
    READY = 1'b0;
    step();
    hold(8'h10, 8'h10, 3);
    READY = 1'b0;
    step();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL ready_gap: valid %b want 0", OUT_VALID);
    end
    hold(8'h10, 8'h10, 3);
    hold(8'h11, 8'h10, 1);
    hold(8'h10, 8'h10, 3);
    READY = 1'b0;
    step();
    checks++;
    if (OUT_VALID !== 1'b0 || DROP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL glitch: got v%b drop %0d want v0 drop 0", OUT_VALID, DROP_CNT);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] ex [4];
    logic [7:0] ey [4];
    logic [8:0] ed [4];
    logic [8:0] d1;
    OUT_ACK = 1'b0;
    d1 = exp_delta(8'h01, 8'h02);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] x, y;
      x = 8'(2 * i + 1);
      y = 8'(2 * i + 2);
      if (i >= 1 && i <= 3) begin
        ex[i-1] = x; ey[i-1] = y; ed[i-1] = exp_delta(x, y);
      end
      if (i < 4) begin
        lx = x; ly = y; lv = 1'b1;
      end
      hold(x, y, 4);
    end
    checks++;
    if (DROP_CNT !== 8'd1) begin
      errors++; $display("FAIL full_drop: got %0d want 1", DROP_CNT);
    end
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_X !== 8'h01 || OUT_Y !== 8'h02 || OUT_DELTA !== d1) begin
      errors++;
      $display("FAIL full_head: got v%b %h,%h,%0d want v1 01,02,%0d",
               OUT_VALID, OUT_X, OUT_Y, OUT_DELTA, d1);
    end
    ex[3] = 8'h0B; ey[3] = 8'h0C; ed[3] = exp_delta(8'h0B, 8'h0C);
    lx = 8'h0B; ly = 8'h0C;
    hold(8'h0B, 8'h0C, 3);
    OUT_ACK = 1'b1;
    step();
    OUT_ACK = 1'b0;
    checks++;
    if (DROP_CNT !== 8'd1) begin
      errors++; $display("FAIL full_pushpop_drop: got %0d want 1", DROP_CNT);
    end
    OUT_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_X !== ex[i] || OUT_Y !== ey[i] || OUT_DELTA !== ed[i]) begin
        errors++;
        $display("FAIL full_drain%0d: got v%b %h,%h,%0d want v1 %h,%h,%0d", i,
                 OUT_VALID, OUT_X, OUT_Y, OUT_DELTA, ex[i], ey[i], ed[i]);
      end
      step();
    end
    OUT_ACK = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL full_count: valid %b after 4 pops want 0", OUT_VALID);
    end
  endtask

  task automatic test_reset_mid();
    OUT_ACK = 1'b0;
    hold(8'h20, 8'h20, 4);
    hold(8'h21, 8'h20, 4);
    hold(8'h22, 8'h20, 4);
    hold(8'h30, 8'h30, 2);
    checks++;
    if (OUT_VALID !== 1'b1 || DROP_CNT !== 8'd1) begin
      errors++;
      $display("FAIL mid_pre: got v%b drop %0d want v1 drop 1", OUT_VALID, DROP_CNT);
    end
    #3;
    RESET = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || DROP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL mid_async: got v%b drop %0d want v0 drop 0", OUT_VALID, DROP_CNT);
    end
    lx = 8'd0; ly = 8'd0; lv = 1'b0;
    step();
    RESET = 1'b1;
    hold(8'h30, 8'h30, 3);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL mid_early: valid %b want 0", OUT_VALID);
    end
    step();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_X !== 8'h30 || OUT_Y !== 8'h30 || OUT_DELTA !== 9'd0) begin
      errors++;
      $display("FAIL mid_after: got v%b %h,%h,%0d want v1 30,30,0",
               OUT_VALID, OUT_X, OUT_Y, OUT_DELTA);
    end
    OUT_ACK = 1'b1;
    step();
    OUT_ACK = 1'b0;
    lx = 8'h30; ly = 8'h30; lv = 1'b1;
  endtask

  task automatic test_wrap();
    logic [24:0] q[$];
    int          pops;
    logic        tog;
    pops = 0;
    tog  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] x, y;
      x = 8'(8'h50 + i);
      y = 8'(8'h60 - 2 * i);
      q.push_back({x, y, exp_delta(x, y)});
      lx = x; ly = y; lv = 1'b1;
      for (int c = 0; c < 4; c++) begin
        READY = 1'b1; Xc = x; Yc = y;
        tog = ~tog;
        OUT_ACK = tog;
        if (OUT_VALID && OUT_ACK) begin
          checks++;
          if (q.size() == 0 || {OUT_X, OUT_Y, OUT_DELTA} !== q[0]) begin
            errors++;
            $display("FAIL wrap_order%0d: got %h,%h,%0d want %h", pops,
                     OUT_X, OUT_Y, OUT_DELTA, (q.size() != 0) ? q[0] : 25'h0);
          end
          if (q.size() != 0) void'(q.pop_front());
          pops++;
        end
        step();
      end
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      OUT_ACK = 1'b1;
      if (OUT_VALID) begin
        checks++;
        if ({OUT_X, OUT_Y, OUT_DELTA} !== q[0]) begin
          errors++;
          $display("FAIL wrap_drain%0d: got %h,%h,%0d want %h", pops,
                   OUT_X, OUT_Y, OUT_DELTA, q[0]);
        end
        void'(q.pop_front());
        pops++;
      end
      step();
    end
    OUT_ACK = 1'b0;
    checks++;
    if (pops != 10 || q.size() != 0) begin
      errors++; $display("FAIL wrap_count: got %0d pops want 10", pops);
    end
    checks++;
    if (OUT_VALID !== 1'b0 || DROP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL wrap_end: got v%b drop %0d want v0 drop 0", OUT_VALID, DROP_CNT);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_first_report();
    test_delta_suppression();
    test_interrupted();
    test_fifo_full();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
